// File: rtl/seq_muldiv.sv
// Iterative multiply/divide unit covering the eight M-extension ops.
// Operands are reduced to magnitudes on entry. W shift-add or shift-subtract steps then run,
// each CPB cycles long. One fix-up cycle picks the result and restores its sign.
// Latency from the accepted start to done is W*CPB+1 for every op and every operand.
module seq_muldiv #(
    parameter int unsigned W   = 32,
    parameter int unsigned CPB = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [2:0]   funct3,
    input  logic [W-1:0] rs1,
    input  logic [W-1:0] rs2,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result
);

    localparam int unsigned Steps = W * CPB;
    localparam int unsigned CntW  = $clog2(Steps);

    typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

    state_e          state_q, state_d;
    logic [2:0]      op_q, op_d;
    logic            neg1_q, neg1_d;
    logic            neg2_q, neg2_d;
    logic [W:0]      p_q, p_d;       // accumulator / partial remainder, one spare bit for carry
    logic [W-1:0]    m_q, m_d;       // multiplier (shifts out) or dividend/quotient
    logic [W-1:0]    b_q, b_d;       // multiplicand magnitude or divisor magnitude
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [W-1:0]    result_q, result_d;
    logic            done_q, done_d;

    // Operand decode at start: which operands are signed, and their magnitudes
    logic         sgn1_in, sgn2_in, neg1_in, neg2_in;
    logic [W-1:0] abs1_in, abs2_in;

    always_comb begin
        sgn1_in = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                  (funct3 == 3'b100) || (funct3 == 3'b110);
        // MULHSU treats rs2 as unsigned, so its MSB is magnitude
        sgn2_in = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
        neg1_in = sgn1_in & rs1[W-1];
        neg2_in = sgn2_in & rs2[W-1];
        abs1_in = neg1_in ? -rs1 : rs1;
        abs2_in = neg2_in ? -rs2 : rs2;
    end

    // Bit-step datapath plus result fix-up
    logic             ph_a, ph_b;    // first / second cycle of a bit step (both when CPB==1)
    logic [W:0]       p_t;
    logic [W-1:0]     m_t;
    logic [W+1:0]     diff;
    logic [2*W-1:0]   prod;
    logic [W-1:0]     quot, rem;

    always_comb begin
        ph_a = (CPB == 1) || cnt_q[0];
        ph_b = (CPB == 1) || !cnt_q[0];
        p_t  = p_q;
        m_t  = m_q;
        diff = '0;
        if (!op_q[2]) begin
            // Multiply: conditional add, then shift {carry,P,M} right
            if (ph_a && m_t[0]) begin
                p_t = {1'b0, p_t[W-1:0]} + {1'b0, b_q};
            end
            if (ph_b) begin
                m_t = {p_t[0], m_t[W-1:1]};
                p_t = {1'b0, p_t[W:1]};
            end
        end else begin
            // Divide: shift {P,M} left, then restoring trial subtract
            if (ph_a) begin
                p_t = {p_t[W-1:0], m_t[W-1]};
                m_t = {m_t[W-2:0], 1'b0};
            end
            if (ph_b) begin
                diff = {1'b0, p_t} - {2'b00, b_q};
                if (!diff[W+1]) begin
                    p_t    = diff[W:0];
                    m_t[0] = 1'b1;
                end
            end
        end

        prod = {p_q[W-1:0], m_q};
        if (neg1_q ^ neg2_q) begin
            prod = -prod;
        end
        quot = m_q;
        if (neg1_q ^ neg2_q) begin
            quot = -quot;
        end
        // Divide by zero yields all ones regardless of signs
        if (b_q == '0) begin
            quot = '1;
        end
        rem = neg1_q ? -p_q[W-1:0] : p_q[W-1:0];
    end

    // Next-state and register updates for the IDLE -> RUN -> FIX sequence
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        neg1_d   = neg1_q;
        neg2_d   = neg2_q;
        p_d      = p_q;
        m_d      = m_q;
        b_d      = b_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        done_d   = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    op_d    = funct3;
                    neg1_d  = neg1_in;
                    neg2_d  = neg2_in;
                    p_d     = '0;
                    m_d     = funct3[2] ? abs1_in : abs2_in;
                    b_d     = funct3[2] ? abs2_in : abs1_in;
                    cnt_d   = CntW'(Steps - 1);
                    state_d = StRun;
                end
            end
            StRun: begin
                p_d   = p_t;
                m_d   = m_t;
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == '0) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                case (op_q)
                    3'b000:                 result_d = prod[W-1:0];
                    3'b001, 3'b010, 3'b011: result_d = prod[2*W-1:W];
                    3'b100, 3'b101:         result_d = quot;
                    default:                result_d = rem;
                endcase
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State register with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            op_q     <= '0;
            neg1_q   <= 1'b0;
            neg2_q   <= 1'b0;
            p_q      <= '0;
            m_q      <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            neg1_q   <= neg1_d;
            neg2_q   <= neg2_d;
            p_q      <= p_d;
            m_q      <= m_d;
            b_q      <= b_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign busy   = (state_q != StIdle);
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_seq_muldiv.sv
// Bench for seq_muldiv. It drives three instances in lockstep: W=8/CPB=2, W=32/CPB=1 and
// W=32/CPB=2. Each instance is compared with a plain-arithmetic reference model.
module tb_seq_muldiv;

    localparam int Wait    = 68;
    localparam int NumRand = 700;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [2:0]  funct3;
    logic [31:0] rs1, rs2;
    logic        st8, st1, st2;
    logic        busy8, busy1, busy2;
    logic        done8, done1, done2;
    logic [7:0]  res8;
    logic [31:0] res1, res2;

    logic [2:0]  dn_v, by_v;
    logic [31:0] r_v [3];
    logic [31:0] got_r [3];
    int          wid [3] = '{8, 32, 32};
    int          lat [3] = '{17, 33, 65};
    int          total = 0;
    int          bad = 0;

    seq_muldiv #(.W(8), .CPB(2)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(st8), .funct3(funct3), .rs1(rs1[7:0]), .rs2(rs2[7:0]),
        .busy(busy8), .done(done8), .result(res8)
    );
    seq_muldiv #(.W(32), .CPB(1)) u_dut_c1 (
        .clk(clk), .rst_n(rst_n), .start(st1), .funct3(funct3), .rs1(rs1), .rs2(rs2),
        .busy(busy1), .done(done1), .result(res1)
    );
    seq_muldiv #(.W(32), .CPB(2)) u_dut_c2 (
        .clk(clk), .rst_n(rst_n), .start(st2), .funct3(funct3), .rs1(rs1), .rs2(rs2),
        .busy(busy2), .done(done2), .result(res2)
    );

    assign dn_v   = {done2, done1, done8};
    assign by_v   = {busy2, busy1, busy8};
    assign r_v[0] = {24'h0, res8};
    assign r_v[1] = res1;
    assign r_v[2] = res2;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: RV32M semantics at width w, using wide integer arithmetic
    function automatic logic [31:0] ref_op(input int w, input logic [2:0] f,
                                           input logic [31:0] a, input logic [31:0] b);
        longint      mask, ua, ub, sa, sb, r, minv;
        logic [63:0] up;
        mask = (longint'(1) << w) - 1;
        ua   = longint'(a) & mask;
        ub   = longint'(b) & mask;
        sa   = ua[w-1] ? ua - (longint'(1) << w) : ua;
        sb   = ub[w-1] ? ub - (longint'(1) << w) : ub;
        minv = -(longint'(1) << (w - 1));
        case (f)
            3'd0: r = ua * ub;
            3'd1: r = (sa * sb) >>> w;
            3'd2: r = (sa * ub) >>> w;
            3'd3: begin
                up = ua * ub;
                r  = longint'(up >> w);
            end
            3'd4: r = (ub == 0) ? mask : (sa == minv && sb == -1) ? sa : sa / sb;
            3'd5: r = (ub == 0) ? mask : ua / ub;
            3'd6: r = (ub == 0) ? sa : (sa == minv && sb == -1) ? 0 : sa % sb;
            default: r = (ub == 0) ? ua : ua % ub;
        endcase
        return 32'(r & mask);
    endfunction

    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        funct3 = f;
        rs1    = a;
        rs2    = b;
        {st2, st1, st8} = 3'b111;
        @(posedge clk);
        #1;
        {st2, st1, st8} = 3'b000;
    endtask

    // One op on all instances; poke_k>0 pulses a stray start while they are busy
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input int poke_k);
        logic [31:0] exp [3];
        int          seen [3];
        int          extra [3];
        logic        busy_at [3];
        for (int i = 0; i < 3; i++) begin
            exp[i]     = ref_op(wid[i], f, a, b);
            seen[i]    = 0;
            extra[i]   = 0;
            busy_at[i] = 1'b1;
            got_r[i]   = '0;
        end
        issue(f, a, b);
        for (int k = 1; k <= Wait; k++) begin
            @(posedge clk);
            #1;
            if (k == poke_k) begin
                funct3 = ~f;
                rs1    = $urandom;
                rs2    = $urandom;
                {st2, st1, st8} = 3'b111;
            end else begin
                {st2, st1, st8} = 3'b000;
            end
            for (int i = 0; i < 3; i++) begin
                if (dn_v[i]) begin
                    if (seen[i] == 0) begin
                        seen[i]    = k;
                        got_r[i]   = r_v[i];
                        busy_at[i] = by_v[i];
                    end else begin
                        extra[i]++;
                    end
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            check($sformatf("lat d%0d f%0d a=%h b=%h", i, f, a, b), 64'(seen[i]), 64'(lat[i]));
            check($sformatf("res d%0d f%0d a=%h b=%h", i, f, a, b), 64'(got_r[i]), 64'(exp[i]));
            check($sformatf("busy_at_done d%0d", i), 64'(busy_at[i]), 64'(0));
            check($sformatf("extra_done d%0d", i), 64'(extra[i]), 64'(0));
        end
    endtask

    task automatic dir8(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [7:0] exp8);
        run_op(f, a, b, 0);
        check(tag, 64'(got_r[0]), 64'(exp8));
    endtask

    task automatic b2b_test();
        int          sec_k;
        logic [31:0] sec_r;
        sec_k = 0;
        sec_r = '0;
        issue(3'b000, 32'h0F, 32'h11);
        for (int k = 1; k <= Wait; k++) begin
            @(posedge clk);
            #1;
            st8 = 1'b0;
            if (k == 17) begin
                check("b2b_first_done", 64'(done8), 64'(1));
                funct3 = 3'b101;
                rs1    = 32'd200;
                rs2    = 32'd7;
                st8    = 1'b1;
            end
            if (k == 20) check("b2b_held", 64'(res8), 64'hFF);
            if (k > 17 && done8 && sec_k == 0) begin
                sec_k = k;
                sec_r = {24'h0, res8};
            end
        end
        check("b2b_lat", 64'(sec_k), 64'(35));
        check("b2b_res", 64'(sec_r), 64'h1C);
    endtask

    task automatic reset_mid();
        int cnt;
        cnt = 0;
        issue(3'b000, 32'h0F0F, 32'h11);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_busy d%0d", i), 64'(by_v[i]), 64'(0));
            check($sformatf("rst_done d%0d", i), 64'(dn_v[i]), 64'(0));
            check($sformatf("rst_res d%0d", i), 64'(r_v[i]), 64'(0));
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (Wait) begin
            @(posedge clk);
            #1;
            if (dn_v != 3'b000) cnt++;
        end
        check("rst_no_done", 64'(cnt), 64'(0));
    endtask

    initial begin
        rst_n  = 1'b0;
        st8    = 1'b0;
        st1    = 1'b0;
        st2    = 1'b0;
        funct3 = '0;
        rs1    = '0;
        rs2    = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset_busy d%0d", i), 64'(by_v[i]), 64'(0));
            check($sformatf("reset_done d%0d", i), 64'(dn_v[i]), 64'(0));
            check($sformatf("reset_res d%0d", i), 64'(r_v[i]), 64'(0));
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        dir8("mul_0f_11",     3'b000, 32'h0F, 32'h11, 8'hFF);
        dir8("mulhu_ff_ff",   3'b011, 32'hFF, 32'hFF, 8'hFE);
        dir8("mulh_80_80",    3'b001, 32'h80, 32'h80, 8'h40);
        dir8("mulhsu_ff_ff",  3'b010, 32'hFF, 32'hFF, 8'hFF);
        dir8("mul_80_ff",     3'b000, 32'h80, 32'hFF, 8'h80);
        dir8("divu_200_7",    3'b101, 32'd200, 32'd7, 8'h1C);
        dir8("remu_200_7",    3'b111, 32'd200, 32'd7, 8'h04);
        dir8("div_f9_02",     3'b100, 32'hF9, 32'h02, 8'hFD);
        dir8("rem_f9_02",     3'b110, 32'hF9, 32'h02, 8'hFF);
        dir8("rem_07_fe",     3'b110, 32'h07, 32'hFE, 8'h01);
        dir8("divu_55_0",     3'b101, 32'h55, 32'h00, 8'hFF);
        dir8("remu_55_0",     3'b111, 32'h55, 32'h00, 8'h55);
        dir8("div_80_0",      3'b100, 32'h80, 32'h00, 8'hFF);
        dir8("div_80_ff",     3'b100, 32'h80, 32'hFF, 8'h80);
        dir8("rem_80_ff",     3'b110, 32'h80, 32'hFF, 8'h00);

        // Stray start while busy must not disturb the running op
        run_op(3'b000, 32'h0F, 32'h11, 3);
        check("busy_ignored_res", 64'(got_r[0]), 64'hFF);

        b2b_test();
        run_op(3'b000, 32'h0F0F, 32'h11, 0);
        reset_mid();

        for (int n = 0; n < NumRand; n++) begin
            logic [2:0]  f;
            logic [31:0] a, b;
            int          sel;
            f   = 3'($urandom_range(0, 7));
            a   = $urandom;
            b   = $urandom;
            sel = $urandom_range(0, 15);
            if (sel == 0) b = '0;
            else if (sel == 1) begin
                a = 32'h8000_0000;
                b = 32'hFFFF_FFFF;
            end else if (sel == 2) begin
                a = 32'hFFFF_FF80;
                b = 32'hFFFF_FFFF;
            end else if (sel == 3) b = b & 32'hF;
            run_op(f, a, b, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
